// File: rtl/tmds_decoder_if.sv
// Symbol interface of one TMDS receive channel: raw deserialized word in,
// decoded symbol plus alignment status out.
interface tmds_decoder_if;
  logic [9:0] tmds_in;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out;
  logic       valid_out;
  logic       locked_out;
  logic [3:0] offset_out;

  modport master (
    output tmds_in,
    input  data_out, control_out, ve_out, valid_out, locked_out, offset_out
  );

  modport slave (
    input  tmds_in,
    output data_out, control_out, ve_out, valid_out, locked_out, offset_out
  );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS receive decoder for one channel: bit-slip word alignment on runs of
// control tokens, followed by 8b/10b video and control-token decode.
module tmds_decoder #(
  parameter int LOCK_TOKENS   = 8,
  parameter int SEARCH_WINDOW = 4096
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  tmds_decoder_if.slave bus
);
  localparam int WIN_W = $clog2(SEARCH_WINDOW);
  localparam int RUN_W = $clog2(LOCK_TOKENS + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_TOKENS);
  localparam logic [RUN_W-1:0] RUN_NEAR = RUN_W'(LOCK_TOKENS - 1);

  typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

  function automatic logic [7:0] video_decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d    = 8'h00;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  logic [9:0]       prev_r;
  logic [9:0]       sym_r;
  logic [3:0]       offset_r;
  logic [WIN_W-1:0] win_cnt_r;
  logic [RUN_W-1:0] ctl_run_r;
  state_t           state_r;
  logic [7:0]       data_r;
  logic [1:0]       control_r;
  logic             ve_r;
  logic             valid_r;

  logic [19:0]      window_s;
  logic [9:0]       aligned_s;
  logic             is_ctl_s;
  logic [1:0]       ctl_val_s;
  logic [7:0]       video_s;
  logic             run_hit_s;
  logic             timeout_s;

  assign window_s  = {bus.tmds_in, prev_r};
  assign aligned_s = window_s[{1'b0, offset_r} +: 10];
  assign video_s   = video_decode(sym_r);
  assign run_hit_s = is_ctl_s && (ctl_run_r >= RUN_NEAR);
  assign timeout_s = (win_cnt_r == WIN_LAST);

  // Control-token recognition on the aligned symbol.
  always_comb begin
    is_ctl_s  = 1'b1;
    ctl_val_s = 2'b00;
    case (sym_r)
      10'b1101010100: ctl_val_s = 2'b00;
      10'b0010101011: ctl_val_s = 2'b01;
      10'b0101010100: ctl_val_s = 2'b10;
      10'b1010101011: ctl_val_s = 2'b11;
      default: begin
        is_ctl_s  = 1'b0;
        ctl_val_s = 2'b00;
      end
    endcase
  end

  // Word capture: previous raw word and the bit-rotated symbol.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      prev_r <= 10'd0;
      sym_r  <= 10'd0;
    end else begin
      prev_r <= bus.tmds_in;
      sym_r  <= aligned_s;
    end
  end

  // Alignment FSM with its run counter, search window timer and slip offset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r   <= ST_SEARCH;
      offset_r  <= 4'd0;
      win_cnt_r <= '0;
      ctl_run_r <= '0;
    end else begin
      win_cnt_r <= win_cnt_r + 1'b1;
      if (!is_ctl_s) begin
        ctl_run_r <= '0;
      end else if (ctl_run_r != RUN_MAX) begin
        ctl_run_r <= ctl_run_r + 1'b1;
      end
      // A run completing on the timeout cycle takes priority over the timeout.
      case (state_r)
        ST_SEARCH: begin
          if (run_hit_s) begin
            state_r   <= ST_LOCKED;
            win_cnt_r <= '0;
          end else if (timeout_s) begin
            offset_r  <= (offset_r == 4'd9) ? 4'd0 : offset_r + 4'd1;
            win_cnt_r <= '0;
            ctl_run_r <= '0;
          end
        end
        ST_LOCKED: begin
          if (run_hit_s) begin
            win_cnt_r <= '0;
          end else if (timeout_s) begin
            state_r   <= ST_SEARCH;
            win_cnt_r <= '0;
            ctl_run_r <= '0;
          end
        end
        default: begin
          state_r <= ST_SEARCH;
        end
      endcase
    end
  end

  // Decode stage; valid follows the lock state so both qualify the same symbol.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_r    <= 8'h00;
      control_r <= 2'b00;
      ve_r      <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      valid_r <= (state_r == ST_LOCKED);
      if (is_ctl_s) begin
        ve_r      <= 1'b0;
        data_r    <= 8'h00;
        control_r <= ctl_val_s;
      end else begin
        ve_r   <= 1'b1;
        data_r <= video_s;
      end
    end
  end

  assign bus.data_out    = data_r;
  assign bus.control_out = control_r;
  assign bus.ve_out      = ve_r;
  assign bus.valid_out   = valid_r;
  assign bus.locked_out  = (state_r == ST_LOCKED);
  assign bus.offset_out  = offset_r;
endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: reset, aligned lock, decode, lock loss,
// bit-slip search, offset wrap and run-versus-timeout priority.
module tb_tmds_decoder;
  localparam int LOCK_TOKENS   = 8;
  localparam int SEARCH_WINDOW = 16;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] V00 = 10'h100;
  localparam logic [9:0] VFF = 10'h200;
  // T00 stream whose symbol boundary sits 3 bits into each word.
  localparam logic [9:0] T00_SLIP3 = 10'b1010100110;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  int   n_vec    = 0;
  int   n_err    = 0;

  tmds_decoder_if bus_if ();

  tmds_decoder #(
    .LOCK_TOKENS  (LOCK_TOKENS),
    .SEARCH_WINDOW(SEARCH_WINDOW)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus_if)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},    bus_if.data_out, 8'h00);
    check({tag, "_control"}, {6'd0, bus_if.control_out}, 8'h00);
    check({tag, "_ve"},      {7'd0, bus_if.ve_out}, 8'h00);
    check({tag, "_valid"},   {7'd0, bus_if.valid_out}, 8'h00);
    check({tag, "_locked"},  {7'd0, bus_if.locked_out}, 8'h00);
    check({tag, "_offset"},  {4'd0, bus_if.offset_out}, 8'h00);
  endtask

  initial begin
    bus_if.tmds_in = T00;
    rst_n_in       = 1'b0;
    tick(2);
    check_zero("reset_hold");

    // Aligned lock: 8th token reaches the symbol register on edge 9.
    rst_n_in = 1'b1;
    tick(9);
    check("lock_e9_locked", {7'd0, bus_if.locked_out}, 8'd0);
    tick(1);
    check("lock_e10_locked", {7'd0, bus_if.locked_out}, 8'd1);
    check("lock_e10_valid",  {7'd0, bus_if.valid_out}, 8'd0);
    tick(1);
    check("lock_e11_valid",  {7'd0, bus_if.valid_out}, 8'd1);
    check("lock_e11_offset", {4'd0, bus_if.offset_out}, 8'd0);
    check("lock_e11_ve",     {7'd0, bus_if.ve_out}, 8'd0);
    check("lock_e11_ctl",    {6'd0, bus_if.control_out}, 8'd0);

    // Decode: at offset 0 a word is in prev after 1 edge, sym after 2, output after 3.
    bus_if.tmds_in = V00; tick(1);
    bus_if.tmds_in = VFF; tick(1);
    check("dec_v00_not_yet_ve", {7'd0, bus_if.ve_out}, 8'd0);
    bus_if.tmds_in = T11; tick(1);
    check("dec_v00_ve",   {7'd0, bus_if.ve_out}, 8'd1);
    check("dec_v00_data", bus_if.data_out, 8'h00);
    check("dec_v00_ctl",  {6'd0, bus_if.control_out}, 8'd0);
    bus_if.tmds_in = V00; tick(1);
    check("dec_vff_ve",   {7'd0, bus_if.ve_out}, 8'd1);
    check("dec_vff_data", bus_if.data_out, 8'hFF);
    bus_if.tmds_in = T00; tick(1);
    check("dec_t11_ve",    {7'd0, bus_if.ve_out}, 8'd0);
    check("dec_t11_data",  bus_if.data_out, 8'h00);
    check("dec_t11_ctl",   {6'd0, bus_if.control_out}, 8'd3);
    check("dec_t11_valid", {7'd0, bus_if.valid_out}, 8'd1);
    tick(1);
    check("dec_hold_ve",   {7'd0, bus_if.ve_out}, 8'd1);
    check("dec_hold_data", bus_if.data_out, 8'h00);
    check("dec_hold_ctl",  {6'd0, bus_if.control_out}, 8'd3);
    tick(1);
    check("dec_t00_ctl",   {6'd0, bus_if.control_out}, 8'd0);
    tick(12);
    check("dec_relock_held", {7'd0, bus_if.locked_out}, 8'd1);

    // Lock loss: the last run refresh lands 2 edges after video starts.
    bus_if.tmds_in = V00;
    tick(17);
    check("loss_before_locked", {7'd0, bus_if.locked_out}, 8'd1);
    tick(1);
    check("loss_locked", {7'd0, bus_if.locked_out}, 8'd0);
    check("loss_offset", {4'd0, bus_if.offset_out}, 8'd0);
    check("loss_valid_lag", {7'd0, bus_if.valid_out}, 8'd1);
    tick(1);
    check("loss_valid", {7'd0, bus_if.valid_out}, 8'd0);
    bus_if.tmds_in = T00;
    tick(9);
    check("relock_early", {7'd0, bus_if.locked_out}, 8'd0);
    tick(1);
    check("relock_locked", {7'd0, bus_if.locked_out}, 8'd1);
    check("relock_offset", {4'd0, bus_if.offset_out}, 8'd0);

    // Slip search: stream 3 bits late, one slip per 16-cycle window.
    rst_n_in = 1'b0;
    bus_if.tmds_in = T00_SLIP3;
    tick(1);
    rst_n_in = 1'b1;
    tick(15);
    check("slip_e15_off", {4'd0, bus_if.offset_out}, 8'd0);
    tick(1);
    check("slip_e16_off", {4'd0, bus_if.offset_out}, 8'd1);
    tick(15);
    check("slip_e31_off", {4'd0, bus_if.offset_out}, 8'd1);
    tick(1);
    check("slip_e32_off", {4'd0, bus_if.offset_out}, 8'd2);
    tick(16);
    check("slip_e48_off", {4'd0, bus_if.offset_out}, 8'd3);
    tick(8);
    check("slip_e56_locked", {7'd0, bus_if.locked_out}, 8'd0);
    tick(1);
    check("slip_e57_locked", {7'd0, bus_if.locked_out}, 8'd1);
    check("slip_e57_off",    {4'd0, bus_if.offset_out}, 8'd3);
    tick(1);
    check("slip_e58_valid", {7'd0, bus_if.valid_out}, 8'd1);
    check("slip_e58_ve",    {7'd0, bus_if.ve_out}, 8'd0);

    // Mid-stream reset asserted between edges clears everything at once.
    #3;
    rst_n_in = 1'b0;
    #1;
    check_zero("midrst");
    tick(2);
    check("midrst_hold_off",    {4'd0, bus_if.offset_out}, 8'd0);
    check("midrst_hold_locked", {7'd0, bus_if.locked_out}, 8'd0);

    // Wrap: non-token stream forces a slip every window; 9 wraps to 0.
    bus_if.tmds_in = V00;
    rst_n_in = 1'b1;
    tick(144);
    check("wrap_e144_off", {4'd0, bus_if.offset_out}, 8'd9);
    tick(15);
    check("wrap_e159_off", {4'd0, bus_if.offset_out}, 8'd9);
    tick(1);
    check("wrap_e160_off", {4'd0, bus_if.offset_out}, 8'd0);

    // Priority: 8th token in sym at edge 15, run_hit on the timeout cycle.
    rst_n_in = 1'b0;
    bus_if.tmds_in = V00;
    tick(1);
    rst_n_in = 1'b1;
    tick(6);
    bus_if.tmds_in = T00;
    tick(9);
    check("prio_e15_locked", {7'd0, bus_if.locked_out}, 8'd0);
    tick(1);
    check("prio_e16_locked", {7'd0, bus_if.locked_out}, 8'd1);
    check("prio_e16_off",    {4'd0, bus_if.offset_out}, 8'd0);
    tick(17);
    check("prio_hold_locked", {7'd0, bus_if.locked_out}, 8'd1);
    check("prio_hold_off",    {4'd0, bus_if.offset_out}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
